// File: rtl/cpu_arith_pkg.sv
// cpu_arith_pkg: shared operand width, ALU op codes and divider state encoding.
package cpu_arith_pkg;
    localparam int XLEN = 32;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_EQ  = 4'd8;
    localparam logic [3:0] ALU_NE  = 4'd9;
    localparam logic [3:0] ALU_LT  = 4'd10;
    localparam logic [3:0] ALU_GE  = 4'd11;
    localparam logic [3:0] ALU_LTU = 4'd12;
    localparam logic [3:0] ALU_GEU = 4'd13;
    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_FIX} div_state_t;
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/cpu_arith_unit_if.sv
// cpu_arith_unit_if: execute-stage bus into the ALU, multiplier and divider.
interface cpu_arith_unit_if;
    import cpu_arith_pkg::*;
    logic [3:0]      i_alu_op;
    logic [XLEN-1:0] i_alu_op1;
    logic [XLEN-1:0] i_alu_op2;
    logic [XLEN-1:0] o_alu_result;
    logic            o_alu_compare;
    logic            i_mul_start;
    logic            i_mul_signed;
    logic [XLEN-1:0] i_mul_op1;
    logic [XLEN-1:0] i_mul_op2;
    logic            o_mul_valid;
    logic [2*XLEN-1:0] o_mul_result;
    logic            i_div_start;
    logic            i_div_signed;
    logic [XLEN-1:0] i_div_numerator;
    logic [XLEN-1:0] i_div_denominator;
    logic            o_div_busy;
    logic            o_div_valid;
    logic [XLEN-1:0] o_div_result;
    logic [XLEN-1:0] o_div_remainder;
    modport master (
        output i_alu_op, i_alu_op1, i_alu_op2, i_mul_start, i_mul_signed, i_mul_op1, i_mul_op2,
               i_div_start, i_div_signed, i_div_numerator, i_div_denominator,
        input  o_alu_result, o_alu_compare, o_mul_valid, o_mul_result,
               o_div_busy, o_div_valid, o_div_result, o_div_remainder
    );
    modport slave (
        input  i_alu_op, i_alu_op1, i_alu_op2, i_mul_start, i_mul_signed, i_mul_op1, i_mul_op2,
               i_div_start, i_div_signed, i_div_numerator, i_div_denominator,
        output o_alu_result, o_alu_compare, o_mul_valid, o_mul_result,
               o_div_busy, o_div_valid, o_div_result, o_div_remainder
    );
endinterface

// File: rtl/cpu_arith_divider.sv
// cpu_arith_divider: fixed 33-edge restoring radix-2 divider with sign fix-up.
module cpu_arith_divider
    import cpu_arith_pkg::*;
(
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] numerator,
    input  logic [XLEN-1:0] denominator,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    div_state_t state, state_next;
    logic [4:0]      count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] den;
    logic            q_neg;
    logic            r_neg;
    logic [XLEN:0]   trial;
    logic            fits;

    assign trial = {rem, quo[XLEN-1]};
    assign fits  = trial >= {1'b0, den};
    assign busy  = state != DIV_IDLE;

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= DIV_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        state_next = (state == DIV_IDLE && start)  ? DIV_RUN  :
                     (state == DIV_RUN  && &count) ? DIV_FIX  :
                     (state == DIV_FIX)            ? DIV_IDLE : state;
    end

    // a zero divisor keeps the all-ones quotient unsigned so both modes agree
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count     <= '0;
            quo       <= '0;
            rem       <= '0;
            den       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            valid     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                DIV_IDLE: if (start) begin
                    quo   <= magnitude(numerator, is_signed & numerator[XLEN-1]);
                    den   <= magnitude(denominator, is_signed & denominator[XLEN-1]);
                    rem   <= '0;
                    count <= '0;
                    q_neg <= is_signed & (numerator[XLEN-1] ^ denominator[XLEN-1]) & |denominator;
                    r_neg <= is_signed & numerator[XLEN-1];
                end
                DIV_RUN: begin
                    count <= count + 5'd1;
                    rem   <= fits ? trial[XLEN-1:0] - den : trial[XLEN-1:0];
                    quo   <= {quo[XLEN-2:0], fits};
                end
                DIV_FIX: begin
                    quotient  <= magnitude(quo, q_neg);
                    remainder <= magnitude(rem, r_neg);
                    valid     <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/cpu_arith_unit.sv
// cpu_arith_unit: RV32 execute-stage arithmetic: combinational ALU, pipelined
// multiplier and iterative divider sharing one clock.
module cpu_arith_unit #(
    parameter int MUL_LATENCY = 2,
    parameter int XLEN        = 32
) (
    input logic              i_clock,
    input logic              i_reset,
    cpu_arith_unit_if.slave  bus
);
    import cpu_arith_pkg::ALU_ADD, cpu_arith_pkg::ALU_SUB, cpu_arith_pkg::ALU_AND, cpu_arith_pkg::ALU_OR;
    import cpu_arith_pkg::ALU_XOR, cpu_arith_pkg::ALU_SLL, cpu_arith_pkg::ALU_SRL, cpu_arith_pkg::ALU_SRA;
    import cpu_arith_pkg::ALU_EQ, cpu_arith_pkg::ALU_NE, cpu_arith_pkg::ALU_LT, cpu_arith_pkg::ALU_GE;
    import cpu_arith_pkg::ALU_LTU, cpu_arith_pkg::ALU_GEU;

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_cmp;

    assign op1   = bus.i_alu_op1;
    assign op2   = bus.i_alu_op2;
    assign shamt = op2[4:0];

    // compare ops leave alu_res at zero so the flag alone forms the result
    always_comb begin
        alu_res = '0;
        alu_cmp = 1'b0;
        case (bus.i_alu_op)
            ALU_ADD: alu_res = op1 + op2;
            ALU_SUB: alu_res = op1 - op2;
            ALU_AND: alu_res = op1 & op2;
            ALU_OR:  alu_res = op1 | op2;
            ALU_XOR: alu_res = op1 ^ op2;
            ALU_SLL: alu_res = op1 << shamt;
            ALU_SRL: alu_res = op1 >> shamt;
            ALU_SRA: alu_res = $signed(op1) >>> shamt;
            ALU_EQ:  alu_cmp = op1 == op2;
            ALU_NE:  alu_cmp = op1 != op2;
            ALU_LT:  alu_cmp = $signed(op1) < $signed(op2);
            ALU_GE:  alu_cmp = $signed(op1) >= $signed(op2);
            ALU_LTU: alu_cmp = op1 < op2;
            ALU_GEU: alu_cmp = op1 >= op2;
            default: ;
        endcase
    end

    assign bus.o_alu_result  = alu_res | XLEN'(alu_cmp);
    assign bus.o_alu_compare = alu_cmp;

    logic [2*XLEN-1:0]    mul_a;
    logic [2*XLEN-1:0]    mul_b;
    logic [MUL_LATENCY-1:0] mul_v;
    logic [2*XLEN-1:0]    mul_p [MUL_LATENCY];

    assign mul_a = {{XLEN{bus.i_mul_signed & bus.i_mul_op1[XLEN-1]}}, bus.i_mul_op1};
    assign mul_b = {{XLEN{bus.i_mul_signed & bus.i_mul_op2[XLEN-1]}}, bus.i_mul_op2};

    // each stage only loads behind a valid, so the last stage holds its product
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mul_v <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) mul_p[i] <= '0;
        end else begin
            mul_v[0] <= bus.i_mul_start;
            if (bus.i_mul_start) mul_p[0] <= mul_a * mul_b;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                mul_v[i] <= mul_v[i-1];
                if (mul_v[i-1]) mul_p[i] <= mul_p[i-1];
            end
        end
    end

    assign bus.o_mul_valid  = mul_v[MUL_LATENCY-1];
    assign bus.o_mul_result = mul_p[MUL_LATENCY-1];

    cpu_arith_divider u_div (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .start       (bus.i_div_start),
        .is_signed   (bus.i_div_signed),
        .numerator   (bus.i_div_numerator),
        .denominator (bus.i_div_denominator),
        .busy        (bus.o_div_busy),
        .valid       (bus.o_div_valid),
        .quotient    (bus.o_div_result),
        .remainder   (bus.o_div_remainder)
    );
endmodule

// File: tb/tb_cpu_arith_unit.sv
// tb_cpu_arith_unit: scoreboard bench for the ALU, multiplier and divider.
module tb_cpu_arith_unit;
    localparam int L = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [63:0] mul_q [$];
    int          mul_due [$];
    logic [63:0] div_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_arith_unit_if bus();
    cpu_arith_unit #(.MUL_LATENCY(L), .XLEN(32)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));

    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic c;
        r = '0;
        c = 1'b0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = 32'($signed(a) >>> b[4:0]);
            4'd8: c = a == b;
            4'd9: c = a != b;
            4'd10: c = $signed(a) < $signed(b);
            4'd11: c = $signed(a) >= $signed(b);
            4'd12: c = a < b;
            4'd13: c = a >= b;
            default: ;
        endcase
        if (op >= 4'd8 && op <= 4'd13) r = {31'b0, c};
        return {c, r};
    endfunction

    function automatic logic [63:0] div_ref(input logic sg, input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q, r;
        if (d == 0) return {32'hFFFFFFFF, n};
        if (sg && n == 32'h80000000 && d == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
        q = sg ? 32'($signed(n) / $signed(d)) : n / d;
        r = sg ? 32'($signed(n) % $signed(d)) : n % d;
        return {q, r};
    endfunction

    task automatic div_run(input logic sg, input logic [31:0] n, input logic [31:0] d,
                           output logic [31:0] q, output logic [31:0] r,
                           output int busy_n, output int lat, output int vcnt);
        int c0;
        busy_n = 0; lat = -1; vcnt = 0; q = 'x; r = 'x;
        @(posedge clk); #1;
        bus.i_div_start = 1'b1; bus.i_div_signed = sg;
        bus.i_div_numerator = n; bus.i_div_denominator = d;
        c0 = cyc;
        @(posedge clk); #1;
        bus.i_div_start = 1'b0;
        repeat (45) begin
            @(negedge clk);
            busy_n += int'(bus.o_div_busy);
            if (bus.o_div_valid) begin
                vcnt++;
                if (lat < 0) begin
                    lat = cyc - c0 - 1;
                    q = bus.o_div_result;
                    r = bus.o_div_remainder;
                end
            end
        end
    endtask

    task automatic div_check(input string name, input logic sg, input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q, r;
        logic [63:0] exp;
        int busy_n, lat, vcnt;
        div_run(sg, n, d, q, r, busy_n, lat, vcnt);
        exp = div_q.pop_front();
        checks += 4;
        if ({q, r} !== exp) begin failures++; $display("FAIL %s q/r got %h/%h want %h/%h", name, q, r, exp[63:32], exp[31:0]); end
        if (busy_n != 33) begin failures++; $display("FAIL %s busy cycles got %0d want 33", name, busy_n); end
        if (lat != 33) begin failures++; $display("FAIL %s latency got %0d want 33", name, lat); end
        if (vcnt != 1) begin failures++; $display("FAIL %s valid pulses got %0d want 1", name, vcnt); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if ({bus.o_mul_valid, bus.o_div_busy, bus.o_div_valid} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got %b want 000", {bus.o_mul_valid, bus.o_div_busy, bus.o_div_valid});
        end
        if ({bus.o_mul_result, bus.o_div_result, bus.o_div_remainder} !== 128'h0) begin
            failures++; $display("FAIL reset_data got %h/%h/%h want 0", bus.o_mul_result, bus.o_div_result, bus.o_div_remainder);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alu();
        logic [31:0] pa [3] = '{32'hFFFFFFF0, 32'h80000000, 32'h12345678};
        logic [31:0] pb [3] = '{32'h00000004, 32'h00000021, 32'h12345678};
        logic [3:0]  sop [7] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd10, 4'd12, 4'd15};
        logic [32:0] sexp [7] = '{{1'b0, 32'hFFFFFFF4}, {1'b0, 32'hFFFFFFEC}, {1'b0, 32'h0FFFFFFF},
                                  {1'b0, 32'hFFFFFFFF}, {1'b1, 32'h1}, {1'b0, 32'h0}, {1'b0, 32'h0}};
        logic [32:0] exp;
        bus.i_alu_op1 = pa[0];
        bus.i_alu_op2 = pb[0];
        for (int i = 0; i < 7; i++) begin
            bus.i_alu_op = sop[i];
            #1;
            checks++;
            if ({bus.o_alu_compare, bus.o_alu_result} !== sexp[i]) begin
                failures++; $display("FAIL alu_spot op%0d got %b/%h want %b/%h", sop[i], bus.o_alu_compare, bus.o_alu_result, sexp[i][32], sexp[i][31:0]);
            end
        end
        for (int p = 0; p < 3; p++) begin
            for (int op = 0; op < 16; op++) begin
                bus.i_alu_op1 = pa[p];
                bus.i_alu_op2 = pb[p];
                bus.i_alu_op = 4'(op);
                exp = alu_ref(4'(op), pa[p], pb[p]);
                #1;
                checks++;
                if ({bus.o_alu_compare, bus.o_alu_result} !== exp) begin
                    failures++; $display("FAIL alu_sweep p%0d op%0d got %b/%h want %b/%h", p, op, bus.o_alu_compare, bus.o_alu_result, exp[32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic test_mul_back_to_back();
        logic        sg [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] a  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
        logic [31:0] b  [3] = '{32'h00000002, 32'h00000007, 32'h80000000};
        logic [63:0] ex [3] = '{64'h00000001FFFFFFFE, 64'hFFFFFFFFFFFFFFEB, 64'h4000000000000000};
        logic [63:0] exp;
        int due;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    bus.i_mul_start = 1'b1; bus.i_mul_signed = sg[i];
                    bus.i_mul_op1 = a[i]; bus.i_mul_op2 = b[i];
                    mul_q.push_back(ex[i]);
                    mul_due.push_back(cyc + L);
                end
                @(posedge clk); #1;
                bus.i_mul_start = 1'b0;
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (bus.o_mul_valid) begin
                        checks++;
                        if (mul_q.size() == 0) begin
                            failures++; $display("FAIL mul_unexpected got valid with %h want none", bus.o_mul_result);
                        end else begin
                            exp = mul_q.pop_front();
                            due = mul_due.pop_front();
                            if (bus.o_mul_result !== exp || cyc != due) begin
                                failures++; $display("FAIL mul_product got %h at %0d want %h at %0d", bus.o_mul_result, cyc, exp, due);
                            end
                        end
                    end
                end
            end
        join
        checks += 2;
        if (mul_q.size() != 0) begin
            failures++; $display("FAIL mul_missing got %0d outstanding want 0", mul_q.size());
            mul_q.delete(); mul_due.delete();
        end
        @(negedge clk);
        if (bus.o_mul_valid !== 1'b0 || bus.o_mul_result !== ex[2]) begin
            failures++; $display("FAIL mul_hold got %b/%h want 0/%h", bus.o_mul_valid, bus.o_mul_result, ex[2]);
        end
    endtask

    task automatic test_div_basic();
        div_q.push_back({32'hFFFFFFFD, 32'hFFFFFFFF});
        div_check("div_s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
        div_q.push_back({32'd14, 32'd2});
        div_check("div_u_100_7", 1'b0, 32'd100, 32'd7);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] n, d;
            n = $urandom;
            d = $urandom_range(1, 1000) ^ (i == 0 ? 32'hFFFF0000 : 32'h0);
            div_q.push_back(div_ref(1'(i), n, d));
            div_check("div_random", 1'(i), n, d);
        end
    endtask

    task automatic test_div_corners();
        logic [31:0] q, r;
        int vcnt, c0;
        div_q.push_back({32'hFFFFFFFF, 32'd5});
        div_check("div_u_5_0", 1'b0, 32'd5, 32'd0);
        div_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFB});
        div_check("div_s_m5_0", 1'b1, 32'hFFFFFFFB, 32'd0);
        div_q.push_back({32'h80000000, 32'h0});
        div_check("div_s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        div_q.push_back({32'd333, 32'd1});
        @(posedge clk); #1;
        bus.i_div_start = 1'b1; bus.i_div_signed = 1'b0;
        bus.i_div_numerator = 32'd1000; bus.i_div_denominator = 32'd3;
        c0 = cyc;
        @(posedge clk); #1;
        bus.i_div_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.i_div_start = 1'b1; bus.i_div_numerator = 32'd5; bus.i_div_denominator = 32'd0;
        @(posedge clk); #1;
        bus.i_div_start = 1'b0;
        vcnt = 0; q = 'x; r = 'x;
        repeat (80) begin
            @(negedge clk);
            if (bus.o_div_valid) begin
                vcnt++;
                if (vcnt == 1) begin q = bus.o_div_result; r = bus.o_div_remainder; end
            end
        end
        checks += 2;
        if ({q, r} !== div_q.pop_front()) begin failures++; $display("FAIL div_ignore_start got %h/%h want %0d/%0d (started at %0d)", q, r, 333, 1, c0); end
        if (vcnt != 1) begin failures++; $display("FAIL div_ignore_pulses got %0d want 1", vcnt); end
    endtask

    task automatic test_div_reset();
        int vcnt;
        @(posedge clk); #1;
        bus.i_div_start = 1'b1; bus.i_div_signed = 1'b0;
        bus.i_div_numerator = 32'hFFFFFFFF; bus.i_div_denominator = 32'd3;
        @(posedge clk); #1;
        bus.i_div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 3;
        if ({bus.o_div_busy, bus.o_div_valid} !== 2'b00) begin failures++; $display("FAIL div_reset_flags got %b want 00", {bus.o_div_busy, bus.o_div_valid}); end
        if ({bus.o_div_result, bus.o_div_remainder, bus.o_mul_result} !== 128'h0) begin
            failures++; $display("FAIL div_reset_data got %h/%h/%h want 0", bus.o_div_result, bus.o_div_remainder, bus.o_mul_result);
        end
        vcnt = 0;
        repeat (40) begin @(negedge clk); vcnt += int'(bus.o_div_valid); end
        if (vcnt != 0) begin failures++; $display("FAIL div_reset_pulse got %0d want 0", vcnt); end
        div_q.push_back({32'd3, 32'd0});
        div_check("div_after_reset", 1'b0, 32'd9, 32'd3);
    endtask

    initial begin
        bus.i_alu_op = '0; bus.i_alu_op1 = '0; bus.i_alu_op2 = '0;
        bus.i_mul_start = 1'b0; bus.i_mul_signed = 1'b0; bus.i_mul_op1 = '0; bus.i_mul_op2 = '0;
        bus.i_div_start = 1'b0; bus.i_div_signed = 1'b0; bus.i_div_numerator = '0; bus.i_div_denominator = '0;
        test_reset();
        test_alu();
        test_mul_back_to_back();
        test_div_basic();
        test_div_corners();
        test_div_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 500000");
        $fatal(1, "watchdog");
    end
endmodule
